// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// state encoding, image-format widths and small state-decode helpers.
package imem_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int LEN_W      = 16;
  localparam int CSUM_W     = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LOADER_IDLE   = 3'd0,
    LOADER_LEN_HI = 3'd1,
    LOADER_LEN_LO = 3'd2,
    LOADER_DATA   = 3'd3,
    LOADER_CSUM   = 3'd4,
    LOADER_DONE   = 3'd5,
    LOADER_ERR    = 3'd6
  } loader_state_t;

  // States in which the byte link is open.
  function automatic logic loader_streaming(input loader_state_t s);
    return (s == LOADER_LEN_HI) || (s == LOADER_LEN_LO) ||
           (s == LOADER_DATA)   || (s == LOADER_CSUM);
  endfunction

  // The CPU may only run from a clean reset or a verified image.
  function automatic logic loader_holds_cpu(input loader_state_t s);
    return (s != LOADER_IDLE) && (s != LOADER_DONE);
  endfunction

  function automatic logic loader_accepts_start(input loader_state_t s);
    return (s == LOADER_IDLE) || (s == LOADER_DONE) || (s == LOADER_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted stream bytes big-endian into 32-bit words; flags the
// word combinationally in the same cycle its 4th byte is accepted.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  output logic [1:0]        o_byte_cnt
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_accept) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {r_shift[15:0], i_byte};
    end
  end

  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_accept && (r_cnt == 2'd3);
  assign o_byte_cnt   = r_cnt;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream and
// writes it word by word into instruction memory, holding the CPU meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [BYTE_W-1:0] i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [31:0]       o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [BYTE_W-1:0] r_len_hi;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [CSUM_W-1:0] r_xor;

  logic              r_byte_ready;
  logic              r_wr_en;
  logic [31:0]       r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_error;

  logic              w_accept;
  logic              w_data_accept;
  logic              w_start_ok;
  logic [LEN_W-1:0]  w_len;
  logic              w_len_over;
  logic              w_last_word;
  logic              w_final_byte;
  logic [WORD_W-1:0] w_word;
  logic              w_word_valid;
  logic [1:0]        w_byte_cnt;

  assign w_accept      = i_byte_valid && loader_streaming(r_state);
  assign w_data_accept = w_accept && (r_state == LOADER_DATA);
  assign w_start_ok    = i_start && loader_accepts_start(r_state);
  assign w_len         = {r_len_hi, i_byte_in};
  assign w_len_over    = {16'd0, w_len} > MAX_WORDS_U;
  assign w_last_word   = (r_idx + 16'd1) == r_len;
  assign w_final_byte  = w_data_accept && (w_byte_cnt == 2'd3) && w_last_word;

  word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_start_ok),
    .i_accept     (w_data_accept),
    .i_byte       (i_byte_in),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_byte_cnt   (w_byte_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= LOADER_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOADER_IDLE: begin
        if (w_start_ok) w_next = LOADER_LEN_HI;
      end
      LOADER_LEN_HI: begin
        if (w_accept) w_next = LOADER_LEN_LO;
      end
      LOADER_LEN_LO: begin
        if (w_accept) begin
          if (w_len_over)          w_next = LOADER_ERR;
          else if (w_len == 16'd0) w_next = LOADER_CSUM;
          else                     w_next = LOADER_DATA;
        end
      end
      LOADER_DATA: begin
        if (w_final_byte) w_next = LOADER_CSUM;
      end
      LOADER_CSUM: begin
        if (w_accept) w_next = (i_byte_in == r_xor) ? LOADER_DONE : LOADER_ERR;
      end
      LOADER_DONE, LOADER_ERR: begin
        if (w_start_ok) w_next = LOADER_LEN_HI;
      end
      default: w_next = LOADER_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte_ready <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_byte_ready <= loader_streaming(w_next);
      r_cpu_hold   <= loader_holds_cpu(w_next);
      r_done       <= (w_next == LOADER_DONE);
      r_error      <= (w_next == LOADER_ERR);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_hi  <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_xor     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 32'd0;
      r_wr_data <= 32'd0;
    end else begin
      r_wr_en <= w_word_valid;
      if (w_word_valid) begin
        r_wr_addr <= BASE_ADDR + {14'd0, r_idx, 2'b00};
        r_wr_data <= w_word;
        r_idx     <= r_idx + 16'd1;
      end
      if (w_start_ok) begin
        r_len_hi <= '0;
        r_len    <= '0;
        r_idx    <= '0;
        r_xor    <= '0;
      end else if (w_accept && (r_state != LOADER_CSUM)) begin
        r_xor <= r_xor ^ i_byte_in;
        if (r_state == LOADER_LEN_HI) r_len_hi <= i_byte_in;
        if (r_state == LOADER_LEN_LO) r_len    <= w_len;
      end
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader; expected writes and outcome
// come from a byte-stream model built from the image word list.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        wrEn;
  logic [31:0] wrAddr;
  logic [31:0] wrData;
  logic        cpuHold;
  logic        done;
  logic        error;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  int          pulseErrs = 0;
  logic        prevWrEn  = 1'b0;

  logic [31:0] imgWords[$];
  logic [7:0]  stream[$];

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_byte_in    (byteIn),
    .i_byte_valid (byteValid),
    .o_byte_ready (byteReady),
    .o_wr_en      (wrEn),
    .o_wr_addr    (wrAddr),
    .o_wr_data    (wrData),
    .o_cpu_hold   (cpuHold),
    .o_done       (done),
    .o_error      (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe and flag any strobe wider than one cycle.
  always @(negedge clk) begin
    if (wrEn) begin
      obsAddr.push_back(wrAddr);
      obsData.push_back(wrData);
      if (prevWrEn) pulseErrs <= pulseErrs + 1;
    end
    prevWrEn <= wrEn;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One byte, preceded by a random idle gap of up to gapMax cycles.
  task automatic applyStimulus(input logic [7:0] b, input int gapMax);
    int g;
    g = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      byteValid = 1'b0;
      byteIn    = 8'($urandom);
    end
    @(negedge clk);
    byteValid = 1'b1;
    byteIn    = b;
  endtask

  // Reference model: length header, big-endian words, XOR of all prior bytes.
  task automatic buildStream(input bit badCsum);
    logic [15:0] n;
    logic [7:0]  x;
    stream.delete();
    n = 16'(imgWords.size());
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    foreach (imgWords[w]) begin
      for (int k = 3; k >= 0; k--) stream.push_back(imgWords[w][8*k +: 8]);
    end
    x = 8'h00;
    foreach (stream[i]) x = x ^ stream[i];
    stream.push_back(x ^ {7'd0, badCsum});
  endtask

  task automatic pulseStart();
    @(negedge clk);
    byteValid = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".ready"}, 32'(byteReady), 32'd0);
    checkOutput({tag, ".wr_en"}, 32'(wrEn), 32'd0);
    checkOutput({tag, ".hold"},  32'(cpuHold), 32'd0);
    checkOutput({tag, ".done"},  32'(done), 32'd0);
    checkOutput({tag, ".error"}, 32'(error), 32'd0);
    checkOutput({tag, ".addr"},  wrAddr, 32'd0);
    checkOutput({tag, ".data"},  wrData, 32'd0);
  endtask

  task automatic runImage(input string tag, input bit badCsum, input int gapMax, input int startAt);
    int base;
    int errBase;
    buildStream(badCsum);
    base    = obsAddr.size();
    errBase = pulseErrs;
    pulseStart();
    checkOutput({tag, ".hold_after_start"},  32'(cpuHold), 32'd1);
    checkOutput({tag, ".ready_after_start"}, 32'(byteReady), 32'd1);
    foreach (stream[i]) begin
      if (i == startAt) begin
        @(negedge clk);
        byteValid = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
      end
      applyStimulus(stream[i], gapMax);
    end
    @(negedge clk);
    byteValid = 1'b0;
    checkOutput({tag, ".done"},  32'(done),  32'(!badCsum));
    checkOutput({tag, ".error"}, 32'(error), 32'(badCsum));
    checkOutput({tag, ".hold"},  32'(cpuHold), 32'(badCsum));
    checkOutput({tag, ".ready_end"}, 32'(byteReady), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput({tag, ".nwrites"}, 32'(obsAddr.size() - base), 32'(imgWords.size()));
    for (int i = 0; i < imgWords.size() && (base + i) < obsAddr.size(); i++) begin
      checkOutput($sformatf("%s.addr%0d", tag, i), obsAddr[base + i], BASE + 32'(4 * i));
      checkOutput($sformatf("%s.data%0d", tag, i), obsData[base + i], imgWords[i]);
    end
    checkOutput({tag, ".pulse_width"}, 32'(pulseErrs - errBase), 32'd0);
  endtask

  task automatic randomWords(input int n);
    imgWords.delete();
    for (int i = 0; i < n; i++) imgWords.push_back($urandom);
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    start     = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'h00;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("idle");

    $display("[TB] normal load");
    imgWords.delete();
    imgWords.push_back(32'h2008_0005);
    imgWords.push_back(32'h0000_0000);
    runImage("normal", 1'b0, 0, -1);

    $display("[TB] bad checksum");
    runImage("badcsum", 1'b1, 0, -1);

    $display("[TB] oversize image");
    base = obsAddr.size();
    pulseStart();
    checkOutput("over.hold_after_start", 32'(cpuHold), 32'd1);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    checkOutput("over.error_early", 32'(error), 32'd0);
    @(negedge clk);
    byteValid = 1'b0;
    checkOutput("over.error", 32'(error), 32'd1);
    checkOutput("over.ready", 32'(byteReady), 32'd0);
    checkOutput("over.done",  32'(done), 32'd0);
    checkOutput("over.hold",  32'(cpuHold), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("over.nwrites", 32'(obsAddr.size() - base), 32'd0);

    $display("[TB] empty image");
    imgWords.delete();
    runImage("empty", 1'b0, 0, -1);

    $display("[TB] gapped stream");
    randomWords(3);
    runImage("gapped", 1'b0, 5, -1);

    $display("[TB] maximum size image");
    randomWords(MAXW);
    runImage("maxsize", 1'b0, 0, -1);

    $display("[TB] reset mid-load");
    randomWords(2);
    buildStream(1'b0);
    pulseStart();
    for (int i = 0; i < 6; i++) applyStimulus(stream[i], 0);
    @(negedge clk);
    byteValid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midreset");
    rst = 1'b0;
    randomWords(4);
    runImage("after_reset", 1'b0, 1, -1);

    $display("[TB] start ignored during data");
    randomWords(3);
    runImage("ignored_start", 1'b0, 0, 5);

    $display("[TB] random loads");
    for (int t = 0; t < 6; t++) begin
      randomWords(int'($urandom_range(8, 1)));
      runImage($sformatf("rand%0d", t), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that receives a program as a byte stream and writes it, one 32-bit word per write, into the CPU's instruction memory. It is the writer side of the instruction fetch path: while it runs it holds the single-cycle CPU off, and it releases the CPU only after the whole image has landed and its checksum has matched. It sits between the host byte link and the instruction-memory write port.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, default 256: largest accepted image size, in words.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: begin a load. Sampled only in IDLE, DONE or ERR.
- `byte_in` input, 8 bits: stream byte.
- `byte_valid` input, 1 bit: `byte_in` is valid this cycle.
- `byte_ready` output, 1 bit: the loader accepts a byte this cycle.
- `wr_en` output, 1 bit: instruction-memory write strobe, a one-cycle pulse.
- `wr_addr` output, 32 bits: byte address of the write.
- `wr_data` output, 32 bits: instruction word.
- `cpu_hold` output, 1 bit: stalls CPU fetch and register/memory writes.
- `done` output, 1 bit: the image loaded and the checksum matched.
- `error` output, 1 bit: the load was aborted.

## Operation
- Stream format:
  - LEN_HI, LEN_LO: word count N, 16 bits, big-endian.
  - Then 4·N data bytes, each word big-endian (first byte goes to bits [31:24]).
  - Then one checksum byte: the XOR of every byte before it, including both length bytes.
- A byte is accepted in a cycle where `byte_valid && byte_ready`.
- States:
  - IDLE. On `start`, go to S_LEN_HI.
  - S_LEN_HI. Accept a byte, go to S_LEN_LO.
  - S_LEN_LO. Accept a byte, then:
    - N > MAX_WORDS: go to ERR.
    - N == 0: go to S_CSUM.
    - otherwise: go to S_DATA.
  - S_DATA. Collect 4 bytes per word. On the 4th byte, launch a write. After word N-1, go to S_CSUM.
  - S_CSUM. Accept a byte. If it equals the running XOR, go to DONE; otherwise go to ERR.
  - DONE / ERR. Stay there. `start` restarts at S_LEN_HI, clearing the byte counter, the word index and the running XOR.
- `byte_ready` is 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM; it is 0 in IDLE, DONE and ERR.
- Write rule:
  - `wr_addr` = BASE_ADDR + 4·index, where index runs 0..N-1.
  - The address arithmetic is 32-bit and wraps modulo 2^32.
- `cpu_hold`:
  - 1 from the cycle after `start` is accepted through ERR.
  - 0 in IDLE and DONE.
  - A failed image therefore never runs.
- `done` is 1 only in DONE. `error` is 1 only in ERR.
- `start` in S_LEN_HI..S_CSUM is ignored.
- `rst` has priority over everything, including mid-load. It returns the block to IDLE with every output at its reset value. Memory contents already written are not undone.

## Timing
- Reset values: `byte_ready`, `wr_en`, `cpu_hold`, `done` and `error` are 0; `wr_addr` and `wr_data` are 0.
- All outputs are registered.
- `wr_en` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. `wr_addr` and `wr_data` are stable in that cycle.
- Bytes may arrive back-to-back, one per cycle. No backpressure is needed: a write never blocks byte acceptance. A write pulse can coincide with acceptance of the next word's first byte.
- State transitions take effect in the cycle after the accepting edge:
  - `done` or `error` rises one cycle after the checksum byte is accepted.
  - On oversize N, `error` rises one cycle after LEN_LO is accepted.
- Gaps in `byte_valid` of any length are allowed; the state is held during them.
- Minimum load time is 4N+3 cycles after the first byte, plus 1 cycle to reach DONE.

## Structure
- Shared CPU package holds:
  - the loader state encoding (7 states, 3 bits);
  - the `LOADER_*` state constants;
  - the image-format constants (length width 16, checksum width 8).
- One natural sub-module, `word_assembler`. It takes bytes plus an accept strobe and produces a 32-bit word, a one-cycle `word_valid`, and a 2-bit byte counter with a clear input. The FSM, index counter, XOR accumulator and output registers stay in `imem_loader`.

## Test plan
- **Normal load.** `rst`, then `start`, then stream 00 02 | 20 08 00 05 | 00 00 00 00 | csum=0x2F.
  - Two `wr_en` pulses: (0x0, 0x20080005) and (0x4, 0x00000000).
  - `done`=1, `cpu_hold`=0.
- **Bad checksum.** Same stream with csum=0x2E.
  - Both writes still occur.
  - `error`=1, `cpu_hold` stays 1, `done`=0.
- **Oversize and empty images.**
  - N=0x0101 with MAX_WORDS=256: `error` rises one cycle after LEN_LO; no `wr_en`.
  - N=0 then csum 0x00: `done` with zero writes.
- **Gapped stream.** Random `byte_valid` gaps of 0–5 cycles on a 3-word image with BASE_ADDR=0x400.
  - Addresses are 0x400, 0x404, 0x408; data matches; each `wr_en` is exactly 1 cycle.
- **Reset mid-load.** Assert `rst` after the 6th byte.
  - Next cycle: IDLE, all outputs 0.
  - A subsequent full load succeeds and writes from index 0.
- **Restart and ignored start.**
  - `start` pulsed during S_DATA: no effect.
  - `start` in DONE: the next stream reloads, and `cpu_hold` reasserts the following cycle.
